gf_mult_seq: RTL

GF_MULT_SEQ -- requirements
Module: gf_mult_seq

---
 rtl/gf_mult_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/gf_mult_seq.sv
// Sequential GF(2^4) multiplier: MSB-first shift-and-add over four cycles with
// reduction by a caller-supplied field polynomial, plus a small assertion checker.

module gf_mult_seq_chk (
    input logic       clock,
    input logic       reset,
    input logic       done,
    input logic       ready,
    input logic       is_one,
    input logic [3:0] out
);

    done_ready_a: assert property (@(posedge clock) disable iff (reset) done |-> ready);
    done_pulse_a: assert property (@(posedge clock) disable iff (reset) done |=> !done);
    is_one_a:     assert property (@(posedge clock) disable iff (reset) is_one == (out == 4'b0001));

endmodule

module gf_mult_seq (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [4:0] f,
    output logic [3:0] out,
    output logic       done,
    output logic       ready,
    output logic       is_one
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_r;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic [3:0] poly_r;
    logic [3:0] acc_r;
    logic [1:0] idx_r;
    logic [3:0] step_s;
    // x^4 is always folded back as poly[3:0], so the leading coefficient never matters
    logic       f_msb_unused_s;

    assign f_msb_unused_s = f[4];

    // One multiply step: reduce the shifted accumulator, then conditionally add the multiplicand
    function automatic logic [3:0] gf_step(
        input logic [3:0] acc,
        input logic [3:0] mcand,
        input logic [3:0] poly,
        input logic       mbit
    );
        logic [3:0] t;
        t = {acc[2:0], 1'b0} ^ (acc[3] ? poly : 4'b0000);
        return mbit ? (t ^ mcand) : t;
    endfunction

    // Next accumulator value for the current bit index
    always_comb begin
        step_s = gf_step(acc_r, a_r, poly_r, b_r[idx_r]);
    end

    // Control FSM, operand latches, accumulator and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            a_r     <= 4'b0000;
            b_r     <= 4'b0000;
            poly_r  <= 4'b0000;
            acc_r   <= 4'b0000;
            idx_r   <= 2'd0;
            out     <= 4'b0000;
            done    <= 1'b0;
            ready   <= 1'b1;
            is_one  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        poly_r  <= f[3:0];
                        acc_r   <= 4'b0000;
                        idx_r   <= 2'd3;
                        ready   <= 1'b0;
                        state_r <= RUN;
                    end else begin
                        ready   <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_r <= step_s;
                    idx_r <= idx_r - 2'd1;
                    if (idx_r == 2'd0) begin
                        out     <= step_s;
                        is_one  <= (step_s == 4'b0001);
                        done    <= 1'b1;
                        ready   <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        ready   <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    ready   <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    gf_mult_seq_chk u_chk (
        .clock  (clock),
        .reset  (reset),
        .done   (done),
        .ready  (ready),
        .is_one (is_one),
        .out    (out)
    );

endmodule
